sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH, default 8: word width in bits, >= 1.
REQ-003 Parameter FIFO_DEPTH, default 16: word count; power of two, >= 2; DB = $clog2(FIFO_DEPTH).
REQ-004 Parameter SHOWAHEAD, default 1: 1 = first-word-fall-through, 0 = registered read data.
REQ-005 Parameter AFULL_THR, default FIFO_DEPTH-2: almost_full threshold, range 1..FIFO_DEPTH.
REQ-006 Parameter AEMPTY_THR, default 2: almost_empty threshold, range 0..FIFO_DEPTH-1.
REQ-007 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush.
- wdata  in  DATA_WIDTH  write data.
- wr  in  1  write request.
- full  out  1  no free word.
- almost_full  out  1  usedw >= AFULL_THR.
- overflow  out  1  sticky: write attempted while full.
- rdata  out  DATA_WIDTH  read data.
- rd  in  1  read request.
- empty  out  1  no stored word.
- almost_empty  out  1  usedw <= AEMPTY_THR.
- underflow  out  1  sticky: read attempted while empty.
- usedw  out  DB+1  stored word count, 0..FIFO_DEPTH inclusive.

Function
REQ-008 A write SHALL be accepted when wr=1 and full=0: wdata is stored at the write pointer at the clock edge, and the write pointer advances by 1.
REQ-009 A read SHALL be accepted when rd=1 and empty=0; the read pointer advances by 1.
REQ-010 Pointers SHALL be DB+1 bits and wrap modulo 2*FIFO_DEPTH.
- empty = (wp == rp).
- full = low DB bits equal and MSBs differ.
- usedw = wp - rp, computed in DB+1 bits.
REQ-011 A simultaneous accepted read and write SHALL leave usedw unchanged.
REQ-012 With full=1, wr=1 and rd=1 in the same cycle, the read SHALL be accepted, the write rejected, and overflow set.
REQ-013 With empty=1, wr=1 and rd=1 in the same cycle, the write SHALL be accepted, the read rejected, and underflow set.
REQ-014 For SHOWAHEAD=1, rdata SHALL combinationally equal mem[rp] while empty=0, and 0 while empty=1; a written word is visible on rdata 1 cycle after the write edge.
REQ-015 For SHOWAHEAD=0, rdata SHALL register mem[rp] on each accepted-read edge and hold its value otherwise; read latency is 1 cycle.
REQ-016 almost_full and almost_empty SHALL be derived combinationally from the registered pointers only, with no dependence on wr, rd or clr.
REQ-017 overflow SHALL set on any cycle with wr=1 and full=1, and underflow on any cycle with rd=1 and empty=1; both hold until clr or reset.
REQ-018 clr=1 SHALL, at the clock edge, zero wp and rp, clear overflow and underflow, and zero the registered rdata.
- clr overrides wr and rd in the same cycle: neither is accepted and no sticky flag is set.
- Memory contents are not cleared.
REQ-019 The block SHALL contain no flow-control state beyond the pointers, the sticky flags and the registered rdata.

Reset
REQ-020 Assertion of rst_n=0 SHALL immediately, without waiting for a clock, zero wp, rp, overflow, underflow and the registered rdata.
REQ-021 Outputs during and after reset SHALL be: empty=1, full=0, usedw=0, almost_empty=1, almost_full=0 (AFULL_THR >= 1), rdata=0.
REQ-022 Reset asserted mid-operation SHALL discard all stored words; memory is not reset.

Structure
REQ-023 Package fifo_pkg SHALL hold the width helper function (DB+1 pointer width) and the SHOWAHEAD mode constants.
REQ-024 The storage array SHALL be a sub-module, fifo_ram: one write port and one asynchronous read port, no reset.
REQ-025 Parameter-range violations SHALL be caught by elaboration-time assertions.

Verification (DATA_WIDTH=8, FIFO_DEPTH=16, AFULL_THR=14, AEMPTY_THR=2)
REQ-026 Fill and drain: write 0x00..0x0F, then read 16 words.
- Required: full=1 with usedw=16 after the 16th write; read data returns 0x00..0x0F in order; then empty=1.
REQ-027 Thresholds: write 14 words.
- Required: almost_full rises on the 14th write edge; almost_empty falls on the 3rd write edge.
REQ-028 Boundaries: wr+rd while full, then wr+rd while empty.
- Required: usedw goes 16->15 with overflow=1; then usedw goes 0->1 with underflow=1; clr clears both flags.
REQ-029 Wrap-around: run 40 cycles of continuous wr+rd at usedw=5.
- Required: usedw stays 5; data is in order across two pointer wraps.
REQ-030 Mode and reset: with SHOWAHEAD=0, write 0xA5 then read.
- Required: rdata=0xA5 one cycle after the rd edge.
- Assert rst_n mid-burst: outputs match REQ-021 before the next clk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned SHOWAHEAD_REG  = 0;
    localparam int unsigned SHOWAHEAD_FWFT = 1;

    // Pointer width: one extra bit over the address so full and empty differ.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo: one write port and an asynchronous read port, no reset.
module fifo_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_c_o
);

    localparam int unsigned WORDS = 32'd1 << AW;

    logic [DW-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with sticky overflow/underflow, threshold flags and
// selectable first-word-fall-through or registered read data.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SHOWAHEAD  = SHOWAHEAD_FWFT,
    parameter int unsigned AFULL_THR  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_THR = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic                                 wr,
    output logic                                 full,
    output logic                                 almost_full,
    output logic                                 overflow,
    output logic [DATA_WIDTH-1:0]                rdata,
    input  logic                                 rd,
    output logic                                 empty,
    output logic                                 almost_empty,
    output logic                                 underflow,
    output logic [ptr_width(FIFO_DEPTH)-1:0]     usedw
);

    localparam int unsigned PW = ptr_width(FIFO_DEPTH);
    localparam int unsigned AW = PW - 1;

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo: DATA_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (SHOWAHEAD > 1) begin : g_bad_mode
        $error("sync_fifo: SHOWAHEAD must be 0 or 1");
    end
    if (AFULL_THR < 1 || AFULL_THR > FIFO_DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_THR must be in 1..FIFO_DEPTH");
    end
    if (AEMPTY_THR > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THR must be in 0..FIFO_DEPTH-1");
    end

    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  empty_c, full_c, wr_acc_c, rd_acc_c;
    logic [PW-1:0]         usedw_c;
    logic [DATA_WIDTH-1:0] ram_rdata_c;

    // Status derived from the registered pointers only.
    assign empty_c  = (wp_q == rp_q);
    assign full_c   = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign usedw_c  = wp_q - rp_q;
    assign wr_acc_c = wr && !full_c && !clr;
    assign rd_acc_c = rd && !empty_c && !clr;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (wr_acc_c) wp_d = wp_q + PW'(1);
            if (rd_acc_c) rp_d = rp_q + PW'(1);
            if (wr && full_c) ovf_d = 1'b1;
            if (rd && empty_c) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    fifo_ram #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_ram (
        .clk       (clk),
        .we_i      (wr_acc_c),
        .waddr_i   (wp_q[AW-1:0]),
        .wdata_i   (wdata),
        .raddr_i   (rp_q[AW-1:0]),
        .rdata_c_o (ram_rdata_c)
    );

    if (SHOWAHEAD == SHOWAHEAD_FWFT) begin : g_fwft
        assign rdata = empty_c ? '0 : ram_rdata_c;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (clr) begin
                rdata_d = '0;
            end else if (rd_acc_c) begin
                rdata_d = ram_rdata_c;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end

    assign full         = full_c;
    assign empty        = empty_c;
    assign usedw        = usedw_c;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign almost_full  = (usedw_c >= PW'(AFULL_THR));
    assign almost_empty = (usedw_c <= PW'(AEMPTY_THR));

endmodule
